// File: rtl/uart_tx_sched_if.sv
// Requester-side and serializer-side signals of the shared UART transmit scheduler.
// The scheduler takes the slave view; the requesters and the uart_send hookup take the master view.
interface uart_tx_sched_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           uart_start;
    logic [7:0]     uart_data;

    modport master (
        output req, req_data,
        input  ack, grant_id, busy, uart_start, uart_data
    );

    modport slave (
        input  req, req_data,
        output ack, grant_id, busy, uart_start, uart_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_send serializer among N byte requesters.
// uart_send has no busy output, so each frame is timed locally with a down-counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | line free; grant the first requester at or after ptr
//   ST_WAIT | frame (or post-reset holdoff) on the line; cnt counts it down
module uart_tx_sched #(
    parameter int unsigned N            = 4,
    parameter int unsigned IDW          = 2,
    parameter int unsigned FRAME_CYCLES = 52200
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_tx_sched_if.slave bus
);
    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    localparam logic [31:0] CNT_RELOAD = 32'(FRAME_CYCLES - 1);

    state_e         state_q;
    logic [31:0]    cnt_q;
    logic [IDW-1:0] ptr_q;
    logic           busy_q;
    logic           start_q;
    logic [N-1:0]   ack_q;
    logic [7:0]     data_q;
    logic [IDW-1:0] gid_q;

    logic           found_d;
    logic [IDW-1:0] win_id_d;
    logic [7:0]     win_data_d;
    logic [N-1:0]   onehot_d;
    logic [IDW-1:0] ptr_d;

    logic [7:0] req_byte [N];

    for (genvar g = 0; g < N; g++) begin : g_bytes
        assign req_byte[g] = bus.req_data[8*g +: 8];
    end

    // Search starts at ptr and wraps, so the winner is the first requester after the last grant.
    always_comb begin
        logic [IDW-1:0] idx;
        idx        = '0;
        found_d    = 1'b0;
        win_id_d   = '0;
        win_data_d = 8'h00;
        onehot_d   = '0;
        ptr_d      = ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(ptr_q) + k) % N);
            if (!found_d && bus.req[idx]) begin
                found_d       = 1'b1;
                win_id_d      = idx;
                win_data_d    = req_byte[idx];
                onehot_d[idx] = 1'b1;
                ptr_d         = IDW'((32'(idx) + 32'd1) % N);
            end
        end
    end

    // Reset enters WAIT so a frame left in flight inside uart_send drains before the next start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_RELOAD;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            start_q <= 1'b0;
            ack_q   <= '0;
            data_q  <= 8'h00;
            gid_q   <= '0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_RELOAD;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        ack_q   <= onehot_d;
                        data_q  <= win_data_d;
                        gid_q   <= win_id_d;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= CNT_RELOAD;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.grant_id   = gid_q;
    assign bus.busy       = busy_q;
    assign bus.uart_start = start_q;
    assign bus.uart_data  = data_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a cycle-count reference model predicts grants and busy,
// a negedge monitor compares every cycle, and directed phases cover the documented scenarios.
module tb_uart_tx_sched;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int FC  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.N(N), .IDW(IDW)) bus ();

    uart_tx_sched #(.N(N), .IDW(IDW), .FRAME_CYCLES(FC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
    } grant_t;

    grant_t     sb_q[$];
    int         tests  = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         last_ev = 0;
    int         m_ptr  = 0;
    bit         armed  = 1'b0;
    bit         exp_start = 1'b0;
    bit         exp_busy  = 1'b1;
    logic [7:0] exp_data  = 8'h00;
    int         exp_gid   = 0;

    int         st_n;
    int         st_id   [8];
    logic [7:0] st_data [8];
    int         st_cyc  [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant may happen FC+1 edges after the last grant or reset edge.
    initial begin
        int w;
        forever begin
            @(posedge clk);
            cyc++;
            exp_start = 1'b0;
            if (rst) begin
                armed    = 1'b1;
                last_ev  = cyc;
                m_ptr    = 0;
                exp_data = 8'h00;
                exp_gid  = 0;
            end else if (armed && (cyc - last_ev) >= FC + 1 && bus.req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                exp_start = 1'b1;
                exp_gid   = w;
                exp_data  = bus.req_data[8*w +: 8];
                m_ptr     = (w + 1) % N;
                last_ev   = cyc;
                sb_q.push_back('{id: w, data: exp_data});
            end
            exp_busy = (cyc - last_ev) < FC;
        end
    end

    initial begin
        grant_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("busy", 32'(bus.busy), 32'(exp_busy));
                check("uart_start", 32'(bus.uart_start), 32'(exp_start));
                if (exp_start && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("grant_data", 32'(bus.uart_data), 32'(e.data));
                    check("grant_id", 32'(bus.grant_id), 32'(e.id));
                    check("grant_ack", 32'(bus.ack), 32'(1) << e.id);
                end else begin
                    check("ack_idle", 32'(bus.ack), 32'd0);
                    check("data_held", 32'(bus.uart_data), 32'(exp_data));
                    check("id_held", 32'(bus.grant_id), 32'(exp_gid));
                end
            end
        end
    end

    task automatic collect(input int n, input int budget);
        st_n = 0;
        for (int c = 0; c < budget && st_n < n; c++) begin
            @(negedge clk);
            if (bus.uart_start) begin
                st_id[st_n]   = int'(bus.grant_id);
                st_data[st_n] = bus.uart_data;
                st_cyc[st_n]  = cyc;
                st_n++;
            end
        end
        check("start_count", 32'(st_n), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt, start_cnt, d, g, r;
        int exp_rr [5];
        bus.req      = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Holdoff after reset with no requests.
        busy_cnt  = 0;
        start_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            busy_cnt  += int'(bus.busy);
            start_cnt += int'(bus.uart_start);
        end
        check("holdoff_busy_cycles", 32'(busy_cnt), 32'd20);
        check("holdoff_starts", 32'(start_cnt), 32'd0);

        // Single byte from requester 2.
        bus.req_data[23:16] = 8'h41;
        bus.req[2] = 1'b1;
        d = cyc;
        collect(1, 10);
        check("single_id", 32'(st_id[0]), 32'd2);
        check("single_data", 32'(st_data[0]), 32'h41);
        check("single_ack", 32'(bus.ack), 32'b0100);
        check("single_latency", 32'(st_cyc[0] - d), 32'd1);
        bus.req = '0;
        start_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start_cnt += int'(bus.uart_start);
        end
        check("single_no_repeat", 32'(start_cnt), 32'd0);

        // Round robin over all four requesters.
        do_reset();
        bus.req_data = 32'h13121110;
        bus.req      = 4'b1111;
        collect(5, 200);
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            check("rr_id", 32'(st_id[i]), 32'(exp_rr[i]));
            check("rr_data", 32'(st_data[i]), 32'h10 + 32'(exp_rr[i]));
            if (i > 0) check("rr_spacing", 32'(st_cyc[i] - st_cyc[i-1]), 32'(FC + 1));
        end
        bus.req = '0;

        // Pointer skips idle requesters.
        do_reset();
        bus.req = 4'b1001;
        collect(4, 150);
        for (int i = 0; i < 4; i++)
            check("skip_id", 32'(st_id[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
        bus.req = '0;

        // Late arrival during another requester's frame.
        do_reset();
        bus.req_data = 32'h00002233;
        bus.req      = 4'b0001;
        collect(1, 50);
        g = st_cyc[0];
        bus.req = '0;
        repeat (5) @(negedge clk);
        bus.req[1] = 1'b1;
        collect(1, 50);
        check("late_id", 32'(st_id[0]), 32'd1);
        check("late_data", 32'(st_data[0]), 32'h22);
        check("late_spacing", 32'(st_cyc[0] - g), 32'(FC + 1));
        bus.req = '0;

        // Reset in the middle of a frame restarts the full holdoff.
        do_reset();
        bus.req_data = 32'h000000A5;
        bus.req      = 4'b0001;
        collect(1, 50);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_start", 32'(bus.uart_start), 32'd0);
        check("midreset_ack", 32'(bus.ack), 32'd0);
        rst = 1'b0;
        r = cyc;
        collect(1, 50);
        check("midreset_id", 32'(st_id[0]), 32'd0);
        check("midreset_delay", 32'(st_cyc[0] - r), 32'(FC + 1));
        bus.req = '0;

        // Random traffic including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
            bus.req_data = $urandom;
        end
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        repeat (30) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
